// File: rtl/debug_cmd_rx.sv
// Host-to-target debug command receiver: frames SYNC,CMD,ADDR,DATA,SUM
// packets from the UART byte stream and drives debug regs / CPU halt+step.
//
// Ports:
//   clk, resetn       12 MHz logic clock, async active-low reset
//   uart_rx_strobe    one-cycle strobe qualifying uart_rx_data
//   uart_rx_data      received byte
//   dbg_regs          NUM_REGS x 8-bit registers, reg i at [8*i+7:8*i]
//   cpu_halt          CPU hold level
//   step_req          one-cycle single-step pulse (only while halted)
//   cmd_valid         one-cycle pulse per accepted command
//   cmd_code          code of last accepted command
//   err_count         saturating count of rejected/aborted packets
//   busy              packet in progress (state != IDLE)
module debug_cmd_rx #(
    parameter int          NUM_REGS       = 8,
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  SYNC_BYTE      = 8'hFF,
    parameter bit          HALT_ON_RESET  = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  uart_rx_strobe,
    input  logic [7:0]            uart_rx_data,
    output logic [8*NUM_REGS-1:0] dbg_regs,
    output logic                  cpu_halt,
    output logic                  step_req,
    output logic                  cmd_valid,
    output logic [7:0]            cmd_code,
    output logic [7:0]            err_count,
    output logic                  busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] C_WRITE = 8'h01;
    localparam logic [7:0] C_HALT  = 8'h02;
    localparam logic [7:0] C_RUN   = 8'h03;
    localparam logic [7:0] C_STEP  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_SUM
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    cmd_q, addr_q, data_q;
    logic [7:0]    regs_q [NUM_REGS];
    logic          halt_q;
    logic          step_q;
    logic          valid_q;
    logic [7:0]    code_q;
    logic [7:0]    err_q;

    logic          tmo_hit;
    logic          sum_edge;
    logic          sum_ok;
    logic          code_ok;
    logic          exec_ok;
    logic          err_evt;

    // A strobe on the expiry cycle wins, so the timeout needs !strobe.
    assign tmo_hit = (state_q != S_IDLE) && !uart_rx_strobe &&
                     (tmo_q == TO_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (uart_rx_strobe) begin
            unique case (state_q)
                S_IDLE: if (uart_rx_data == SYNC_BYTE) state_d = S_CMD;
                S_CMD:  if (uart_rx_data != SYNC_BYTE) state_d = S_ADDR;
                S_ADDR: state_d = S_DATA;
                S_DATA: state_d = S_SUM;
                S_SUM:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    // ---------------- output / decode logic ----------------
    always_comb begin
        busy     = (state_q != S_IDLE);
        sum_edge = uart_rx_strobe && (state_q == S_SUM);
        sum_ok   = (8'(cmd_q + addr_q + data_q) == uart_rx_data);
        code_ok  = 1'b0;
        unique case (cmd_q)
            C_WRITE: code_ok = ({1'b0, addr_q} < 9'(NUM_REGS));
            C_HALT,
            C_RUN,
            C_STEP:  code_ok = 1'b1;
            default: code_ok = 1'b0;
        endcase
        exec_ok  = sum_edge && sum_ok && code_ok;
        err_evt  = (sum_edge && !(sum_ok && code_ok)) || tmo_hit;
    end

    // Inactivity timer: runs only inside a packet, cleared by any byte.
    always_comb begin
        tmo_d = tmo_q;
        if (uart_rx_strobe || state_d == S_IDLE) begin
            tmo_d = '0;
        end else if (state_q != S_IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_q  <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            if (uart_rx_strobe) begin
                if (state_q == S_CMD && uart_rx_data != SYNC_BYTE) begin
                    cmd_q <= uart_rx_data;
                end
                if (state_q == S_ADDR) addr_q <= uart_rx_data;
                if (state_q == S_DATA) data_q <= uart_rx_data;
            end
        end
    end

    // ---------------- command effects ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            halt_q  <= HALT_ON_RESET;
            step_q  <= 1'b0;
            valid_q <= 1'b0;
            code_q  <= '0;
            err_q   <= '0;
        end else begin
            valid_q <= exec_ok;
            // STEP looks at the halt level before this command executes.
            step_q  <= exec_ok && (cmd_q == C_STEP) && halt_q;
            if (exec_ok) begin
                code_q <= cmd_q;
                if (cmd_q == C_HALT) halt_q <= 1'b1;
                if (cmd_q == C_RUN)  halt_q <= 1'b0;
            end
            if (err_evt && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (exec_ok && cmd_q == C_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 8'(i)) regs_q[i] <= data_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign dbg_regs[8*g +: 8] = regs_q[g];
    end

    assign cpu_halt  = halt_q;
    assign step_req  = step_q;
    assign cmd_valid = valid_q;
    assign cmd_code  = code_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Testbench for debug_cmd_rx: directed packet scenarios plus random
// byte streams, checked every cycle against a packet-level model.
module tb_debug_cmd_rx;

    localparam int NR  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          strobe = 1'b0;
    logic [7:0]    data = 8'h00;
    logic [8*NR-1:0] dbg_regs;
    logic          cpu_halt, step_req, cmd_valid, busy;
    logic [7:0]    cmd_code, err_count;

    int checks = 0;
    int fails  = 0;
    int step_seen = 0;
    int valid_seen = 0;

    debug_cmd_rx #(
        .NUM_REGS(NR),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE(8'hFF),
        .HALT_ON_RESET(1'b0)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .uart_rx_strobe(strobe),
        .uart_rx_data(data),
        .dbg_regs(dbg_regs),
        .cpu_halt(cpu_halt),
        .step_req(step_req),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    bit m_in;
    int m_n;
    int m_idle;
    int m_b [3];
    int m_regs [NR];
    bit m_halt, m_step, m_valid;
    int m_code, m_err;

    always @(posedge clk or negedge resetn) begin : model
        bit ok;
        if (!resetn) begin
            m_in <= 0; m_n <= 0; m_idle <= 0;
            m_halt <= 0; m_step <= 0; m_valid <= 0;
            m_code <= 0; m_err <= 0;
            for (int i = 0; i < NR; i++) m_regs[i] <= 0;
        end else begin
            m_step  <= 0;
            m_valid <= 0;
            if (strobe) begin
                m_idle <= 0;
                if (!m_in) begin
                    if (data == 8'hFF) begin
                        m_in <= 1;
                        m_n  <= 0;
                    end
                end else if (m_n == 0 && data == 8'hFF) begin
                    m_n <= 0;
                end else if (m_n < 3) begin
                    m_b[m_n] <= int'(data);
                    m_n <= m_n + 1;
                end else begin
                    m_in <= 0;
                    ok = (((m_b[0] + m_b[1] + m_b[2]) % 256) == int'(data)) &&
                         ((m_b[0] == 1 && m_b[1] < NR) ||
                          (m_b[0] >= 2 && m_b[0] <= 4));
                    if (ok) begin
                        m_valid <= 1;
                        m_code  <= m_b[0];
                        if (m_b[0] == 1) m_regs[m_b[1]] <= m_b[2];
                        if (m_b[0] == 2) m_halt <= 1;
                        if (m_b[0] == 3) m_halt <= 0;
                        if (m_b[0] == 4) m_step <= m_halt;
                    end else if (m_err < 255) begin
                        m_err <= m_err + 1;
                    end
                end
            end else if (m_in) begin
                if (m_idle + 1 == TMO) begin
                    m_in <= 0;
                    m_idle <= 0;
                    if (m_err < 255) m_err <= m_err + 1;
                end else begin
                    m_idle <= m_idle + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("busy", {63'b0, busy}, {63'b0, m_in});
        chk("cpu_halt", {63'b0, cpu_halt}, {63'b0, m_halt});
        chk("step_req", {63'b0, step_req}, {63'b0, m_step});
        chk("cmd_valid", {63'b0, cmd_valid}, {63'b0, m_valid});
        chk("cmd_code", 64'(cmd_code), 64'(m_code));
        chk("err_count", 64'(err_count), 64'(m_err));
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("reg%0d", i), 64'(dbg_regs[8*i +: 8]),
                64'(m_regs[i]));
        end
    end

    always @(negedge clk) begin
        if (step_req)  step_seen  <= step_seen + 1;
        if (cmd_valid) valid_seen <= valid_seen + 1;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input logic [7:0] b, input int gap);
        strobe = 1'b1;
        data   = b;
        @(negedge clk);
        strobe = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pkt(input logic [7:0] c, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] s);
        send(8'hFF, 0);
        send(c, 0);
        send(a, 0);
        send(d, 0);
        send(s, 2);
    endtask

    task automatic rst();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    int v0, s0;
    logic [7:0] c, a, d, s;

    initial begin
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("lit_reset_regs", 64'(dbg_regs), 64'h0);
        chk("lit_reset_err", 64'(err_count), 64'h0);
        chk("lit_reset_busy", {63'b0, busy}, 64'h0);

        // single write
        v0 = valid_seen;
        pkt(8'h01, 8'h03, 8'hA5, 8'hA9);
        chk("lit_w_regs", 64'(dbg_regs), 64'h00000000_A5000000);
        chk("lit_w_code", 64'(cmd_code), 64'h01);
        chk("lit_w_pulses", 64'(valid_seen - v0), 64'd1);
        chk("lit_w_err", 64'(err_count), 64'h0);

        // halt / step / run
        rst();
        v0 = valid_seen; s0 = step_seen;
        pkt(8'h04, 8'h00, 8'h00, 8'h04);
        chk("lit_step_run_pulse", 64'(step_seen - s0), 64'd0);
        chk("lit_step_run_valid", 64'(valid_seen - v0), 64'd1);
        pkt(8'h02, 8'h00, 8'h00, 8'h02);
        chk("lit_halt", {63'b0, cpu_halt}, 64'd1);
        s0 = step_seen;
        pkt(8'h04, 8'h00, 8'h00, 8'h04);
        chk("lit_step_halted", 64'(step_seen - s0), 64'd1);
        pkt(8'h03, 8'h00, 8'h00, 8'h03);
        chk("lit_run", {63'b0, cpu_halt}, 64'd0);

        // rejected packets
        rst();
        v0 = valid_seen;
        pkt(8'h01, 8'h02, 8'h55, 8'h00);
        pkt(8'h01, 8'h08, 8'h11, 8'h1A);
        chk("lit_err2", 64'(err_count), 64'd2);
        chk("lit_err_regs", 64'(dbg_regs), 64'h0);
        chk("lit_err_valid", 64'(valid_seen - v0), 64'd0);

        // resync and 0xFF payload
        rst();
        send(8'h00, 0); send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 0);
        send(8'h01, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h00, 2);
        chk("lit_resync_reg0", 64'(dbg_regs[7:0]), 64'hFF);
        chk("lit_resync_err", 64'(err_count), 64'h0);

        // timeout, then recovery, then strobe on the expiry cycle
        rst();
        send(8'hFF, 0);
        send(8'h01, 15);
        chk("lit_tmo_busy15", {63'b0, busy}, 64'd1);
        @(negedge clk);
        chk("lit_tmo_busy16", {63'b0, busy}, 64'd0);
        chk("lit_tmo_err", 64'(err_count), 64'd1);
        pkt(8'h01, 8'h05, 8'h22, 8'h28);
        chk("lit_tmo_reg5", 64'(dbg_regs[47:40]), 64'h22);
        send(8'hFF, 0);
        send(8'h01, 15);
        send(8'h06, 0); send(8'h33, 0); send(8'h3A, 2);
        chk("lit_edge_reg6", 64'(dbg_regs[55:48]), 64'h33);
        chk("lit_edge_err", 64'(err_count), 64'd1);

        // reset mid-packet
        rst();
        send(8'hFF, 0); send(8'h01, 0); send(8'h03, 0);
        rst();
        send(8'hA5, 0); send(8'hA9, 2);
        chk("lit_mid_regs", 64'(dbg_regs), 64'h0);
        chk("lit_mid_err", 64'(err_count), 64'h0);
        chk("lit_mid_busy", {63'b0, busy}, 64'h0);
        chk("lit_mid_code", 64'(cmd_code), 64'h0);

        // saturation with back-to-back bad packets
        repeat (300) begin
            send(8'hFF, 0); send(8'h01, 0); send(8'h02, 0);
            send(8'h55, 0); send(8'h00, 0);
        end
        @(negedge clk);
        chk("lit_sat", 64'(err_count), 64'hFF);

        // random traffic
        rst();
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) begin
                send(8'($urandom), $urandom_range(0, 2));
            end else begin
                c = 8'($urandom_range(0, 5));
                a = 8'($urandom_range(0, 9));
                d = 8'($urandom);
                s = 8'(c + a + d);
                if ($urandom_range(0, 4) == 0) s = s ^ 8'h5A;
                send(8'hFF, $urandom_range(0, 1));
                send(c, ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 2));
                send(a, ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 2));
                send(d, $urandom_range(0, 2));
                send(s, $urandom_range(0, 3));
            end
        end
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/debug_cmd_rx.md
Name: debug_cmd_rx

Overview:
- Host-to-FPGA half of the USB-serial debug link: parses the byte stream arriving from the debugger (uart_rx_strobe/uart_rx_data out of usb_serial) into framed commands.
- Drives a bank of debug registers plus CPU halt/single-step controls.
- Runs in the 12 MHz logic clock domain, alongside the existing debug-byte transmitter that streams data[0..7] followed by 0xFF.

Parameters:
- NUM_REGS, 8, number of 8-bit debug registers exposed on dbg_regs (1..256).
- TIMEOUT_CYCLES, 65535, idle clk cycles allowed between bytes of one packet before abort.
- SYNC_BYTE, 8'hFF, packet start marker (matches the TX frame marker).
- HALT_ON_RESET, 0, reset value of cpu_halt.

Ports:
- clk  input  1  logic clock (12 MHz domain).
- resetn  input  1  asynchronous, active-low reset.
- uart_rx_strobe  input  1  one-cycle strobe: uart_rx_data valid.
- uart_rx_data  input  8  received byte.
- dbg_regs  output  8*NUM_REGS  register i at bits [8*i+7:8*i].
- cpu_halt  output  1  level: CPU held when 1.
- step_req  output  1  one-cycle pulse requesting one CPU step.
- cmd_valid  output  1  one-cycle pulse per accepted command.
- cmd_code  output  8  code of last accepted command.
- err_count  output  8  saturating count of rejected/aborted packets.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync use): FSM=IDLE, dbg_regs=0, cpu_halt=HALT_ON_RESET, step_req=0, cmd_valid=0, cmd_code=0, err_count=0, timeout counter=0. Reset mid-packet discards the partial packet.
- Packet format: SYNC, CMD, ADDR, DATA, SUM. SUM = (CMD+ADDR+DATA) mod 256.
- FSM states: IDLE -> CMD -> ADDR -> DATA -> SUM -> IDLE. The FSM advances only on a uart_rx_strobe cycle; bytes are sampled at that edge.
  - IDLE: SYNC_BYTE -> CMD; any other byte is silently dropped (no error).
  - CMD: SYNC_BYTE stays in CMD (resync, no error); any other byte is latched and the FSM goes to ADDR.
  - ADDR, DATA, SUM: every value including 0xFF is accepted as payload.
- Execution: on the edge that accepts the SUM byte, if the checksum matches and the command is legal, effects are registered at that edge and are visible the following cycle. cmd_valid=1 for exactly that cycle and cmd_code is updated. The FSM returns to IDLE in every case.
- Commands:
  - 0x01 WRITE: if ADDR < NUM_REGS, dbg_regs[ADDR] <= DATA. Otherwise error, no write.
  - 0x02 HALT: cpu_halt <= 1.
  - 0x03 RUN: cpu_halt <= 0.
  - 0x04 STEP: step_req=1 for one cycle if cpu_halt is already 1. Otherwise no pulse, but the command is still accepted (cmd_valid pulses).
  - ADDR and DATA are don't-care for 0x02–0x04 but are still part of the checksum.
  - Any other code: error.
- Error (bad checksum, illegal code, out-of-range address): err_count <= err_count+1, saturating at 255. No register, halt or step change and no cmd_valid.
- Timeout: the counter clears on every strobe and on entry to IDLE, and increments each cycle while not in IDLE.
  - Reaching TIMEOUT_CYCLES with no strobe: FSM -> IDLE, err_count increments.
  - A strobe on the same cycle as the timeout takes priority and the byte is processed normally.
- Strobes are assumed at most one per cycle. Back-to-back strobes on consecutive cycles must be handled with no byte lost.
- step_req is a 12 MHz pulse. Stretching or synchronising it into the slow CPU clock domain is the consumer's responsibility.
- busy is combinational from the state register: (state != IDLE).

Test Plan:
- Bytes FF 01 03 A5 A9 -> dbg_regs[3]=A5, other registers 0; one cmd_valid pulse; cmd_code=01; err_count=0.
- FF 04 00 00 04 with cpu_halt=0 -> no step_req, cmd_valid pulses. Then FF 02 00 00 02 -> cpu_halt=1. Then FF 04 00 00 04 -> step_req high exactly 1 cycle. Then FF 03 00 00 03 -> cpu_halt=0.
- Errors: FF 01 02 55 00 (bad sum) and FF 01 08 11 1A (address out of range, NUM_REGS=8) -> err_count=2, dbg_regs unchanged, no cmd_valid.
- Resync and payload 0xFF: 00 FF FF FF 01 00 FF 00 (the three leading FF resync; sum = 01+00+FF = 00) -> dbg_regs[0]=FF, err_count=0.
- Timeout (TIMEOUT_CYCLES=16): FF 01 then 16 idle cycles -> busy falls, err_count=1. Then FF 01 05 22 28 -> dbg_regs[5]=22. Repeat with a strobe landing exactly on the 16th cycle -> no timeout.
- Reset mid-packet: FF 01 03, assert resetn=0 for 1 cycle, then A5 A9 -> no write, all outputs at reset values. Then 300 bad packets back-to-back -> err_count saturates at FF.
